quad_decoder_counter: RTL and testbench
=======================================

Name: quad_decoder_counter

Overview:
- Quadrature (A/B) incremental-encoder front end with a 4x decoder.
- Synchronises and glitch-filters the two raw encoder channels.
- Decodes each legal Gray transition into a step and direction, and maintains a wrapping position count with synchronous preset.
- Sits between the board-level encoder pins and the position/motion logic. It generates the up/down step stream that the up/down position counters consume.

Parameters:
- WIDTH, 10: position counter width in bits.
- PRESET_VAL, 253: value loaded by preset_in; must fit in WIDTH bits.
- SYNC_STAGES, 2: synchroniser flops per channel; minimum 2.
- FILTER_LEN, 3: consecutive cycles a changed synchronised level must hold before it is accepted; minimum 1.

Ports:
- clk_in, input, 1: single clock.
- rst_in, input, 1: asynchronous, active-high reset.
- preset_in, input, 1: synchronous; loads count_out with PRESET_VAL.
- enable_in, input, 1: counting enable.
- qa_in, input, 1: raw encoder channel A (asynchronous).
- qb_in, input, 1: raw encoder channel B (asynchronous).
- err_clr_in, input, 1: synchronous clear for err_out.
- count_out, output, WIDTH: position count.
- dir_out, output, 1: direction of the last accepted step; 1 = up.
- step_out, output, 1: one-cycle pulse per counted step.
- overflow_out, output, 1: one-cycle pulse on wrap from max to 0.
- underflow_out, output, 1: one-cycle pulse on wrap from 0 to max.
- err_out, output, 1: sticky flag; illegal transition seen.
- ready_out, output, 1: high once initialisation is complete.

Behaviour:
- Reset (async, rst_in=1): all outputs and internal state clear immediately.
  - count_out=0, dir_out=1, step_out=0, overflow_out=0, underflow_out=0, err_out=0, ready_out=0.
  - Synchronisers, filter counters, filtered state and previous state all clear to 0.
  - Reset asserted mid-operation aborts everything with no partial count.
- Init phase: runs for SYNC_STAGES+FILTER_LEN cycles after reset release.
  - Filtered state and previous state load directly from the synchroniser output every cycle.
  - No decode, no step, no error.
  - ready_out rises on the edge that ends the phase. Arbitrary pin levels at reset therefore never cause a false step or error.
- Synchroniser: SYNC_STAGES-flop chain per channel.
- Filter: one counter per channel.
  - If the synchronised level differs from the filtered level, the counter increments.
  - When the counter would reach FILTER_LEN, the filtered level takes the new value and the counter returns to 0.
  - If the levels are equal, the counter returns to 0. A pulse shorter than FILTER_LEN cycles is discarded.
- Decoder: registered comparison of the filtered state {A,B} against the previous state. The previous state updates every cycle.
  - Up (A leads): 00→10→11→01→00.
  - Down: the reverse sequence.
  - No change: nothing happens.
  - Both bits change (00↔11, 10↔01): illegal. err_out is set, no step, no count, and the state is still tracked.
- Latency: a raw input stable before edge 1 produces step_out/count_out change after edge SYNC_STAGES+FILTER_LEN+1, which is edge 6 with defaults.
- Count update, in priority order:
  - preset_in=1: count_out=PRESET_VAL. Any coincident step is dropped (step_out=0, dir_out unchanged, no wrap pulse).
  - Otherwise, if enable_in=1 and a legal step occurs:
    - count_out ±1, modulo 2^WIDTH.
    - step_out=1 for one cycle.
    - dir_out=direction.
    - overflow_out pulses on max→0; underflow_out pulses on 0→max.
  - enable_in=0: filter and decoder keep tracking, but there is no count, no step_out and no dir_out update. Illegal transitions are still flagged.
- err_out: sticky until err_clr_in=1. If a set and a clear occur in the same cycle, the set wins.
- step_out, overflow_out and underflow_out are single-cycle pulses and are 0 in every other cycle.

Test Plan:
- Reset release with qa_in=qb_in=1 held:
  - ready_out rises after 5 edges (defaults).
  - count_out=0, err_out=0, no step_out pulse.
- From 00, apply 10,11,01,00, each held 10 cycles:
  - count_out=4 and dir_out=1.
  - Exactly 4 step_out pulses.
  - Each count change occurs 6 edges after its input change.
- From count 0 in state 00, apply 01:
  - count_out=1023, dir_out=0.
  - underflow_out pulses once.
  - A following step 00 (up from 1023) returns count_out to 0 with an overflow_out pulse.
- Glitch filtering:
  - qa_in high for 2 cycles, then back: count and state unchanged.
  - qa_in high for 3 or more cycles: count increments by 1.
- Illegal transition and error clear:
  - qa_in and qb_in both change 00→11 on the same edge: err_out=1 six edges later, count unchanged.
  - err_clr_in pulse: err_out returns to 0.
  - err_clr_in coincident with a new illegal transition: err_out stays 1.
- Preset and async reset:
  - preset_in coincident with the step cycle: count_out=253, no step_out.
  - rst_in asserted mid-sequence between clock edges: all outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/quad_decoder_counter.sv
// ----------------------------------------------------------------------------
// quad_decoder_counter
//   Quadrature encoder front end with a 4x decoder. Each raw channel passes
//   through a multi-flop synchroniser and a glitch filter. Each legal Gray
//   transition of the filtered {A,B} pair becomes one up or down step on a
//   wrapping position counter.
//
// Ports
//   clk_in        : single clock
//   rst_in        : asynchronous active-high reset, clears everything
//   preset_in     : synchronous load of PRESET_VAL into count_out (wins over steps)
//   enable_in     : counting enable (filter/decoder keep tracking when low)
//   qa_in, qb_in  : raw encoder channels (asynchronous)
//   err_clr_in    : synchronous clear of the sticky error flag
//   count_out     : position count, wraps modulo 2^WIDTH
//   dir_out       : direction of last counted step, 1 = up
//   step_out      : one-cycle pulse per counted step
//   overflow_out  : one-cycle pulse on max -> 0 wrap
//   underflow_out : one-cycle pulse on 0 -> max wrap
//   err_out       : sticky, illegal (two-bit) transition seen
//   ready_out     : high once the initialisation phase has completed
// ----------------------------------------------------------------------------
module quad_decoder_counter #(
    parameter int WIDTH       = 10,
    parameter int PRESET_VAL  = 253,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             preset_in,
    input  logic             enable_in,
    input  logic             qa_in,
    input  logic             qb_in,
    input  logic             err_clr_in,
    output logic [WIDTH-1:0] count_out,
    output logic             dir_out,
    output logic             step_out,
    output logic             overflow_out,
    output logic             underflow_out,
    output logic             err_out,
    output logic             ready_out
);

    localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN;
    localparam int IW       = $clog2(INIT_LEN);
    localparam int FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_LEN - 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] PRESET    = WIDTH'(PRESET_VAL);

    // Position of a Gray state along the up sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_pos = 2'd0;
            2'b10:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_a_p0;
    logic [SYNC_STAGES-1:0] sync_b_p0;
    logic [1:0]             sync_ab;
    logic [FW-1:0]          filt_cnt [2];
    logic [1:0]             filt_ab_p1;
    logic [1:0]             prev_ab_p2;
    logic [IW-1:0]          init_cnt;

    logic [1:0] delta;
    logic       step_up;
    logic       step_dn;
    logic       illegal;

    assign sync_ab = {sync_a_p0[SYNC_STAGES-1], sync_b_p0[SYNC_STAGES-1]};

    // Stage p0: synchronisers. Stage p1: glitch filter. Stage p2: previous state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_a_p0   <= '0;
            sync_b_p0   <= '0;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
            filt_ab_p1  <= '0;
            prev_ab_p2  <= '0;
            init_cnt    <= '0;
            ready_out   <= 1'b0;
        end else begin
            sync_a_p0  <= {sync_a_p0[SYNC_STAGES-2:0], qa_in};
            sync_b_p0  <= {sync_b_p0[SYNC_STAGES-2:0], qb_in};
            prev_ab_p2 <= filt_ab_p1;
            if (!ready_out) begin
                // Adopt whatever level the pins settle at, so the first
                // decoded comparison after init sees no change.
                filt_ab_p1  <= sync_ab;
                prev_ab_p2  <= sync_ab;
                filt_cnt[0] <= '0;
                filt_cnt[1] <= '0;
                if (init_cnt == INIT_LAST) begin
                    ready_out <= 1'b1;
                end else begin
                    init_cnt <= init_cnt + IW'(1);
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (sync_ab[i] != filt_ab_p1[i]) begin
                        if (filt_cnt[i] == FILT_LAST) begin
                            filt_ab_p1[i] <= sync_ab[i];
                            filt_cnt[i]   <= '0;
                        end else begin
                            filt_cnt[i] <= filt_cnt[i] + FW'(1);
                        end
                    end else begin
                        filt_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Position difference mod 4: 1 = one step up, 3 = one step down,
    // 2 = both bits changed (direction unknowable).
    always_comb begin
        delta   = gray_pos(filt_ab_p1) - gray_pos(prev_ab_p2);
        step_up = 1'b0;
        step_dn = 1'b0;
        illegal = 1'b0;
        if (ready_out) begin
            step_up = (delta == 2'd1);
            step_dn = (delta == 2'd3);
            illegal = (delta == 2'd2);
        end
    end

    // Stage p3: count, direction, pulses and sticky error.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_out     <= '0;
            dir_out       <= 1'b1;
            step_out      <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
            err_out       <= 1'b0;
        end else begin
            step_out      <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;

            if (illegal) begin
                err_out <= 1'b1;
            end else if (err_clr_in) begin
                err_out <= 1'b0;
            end

            if (preset_in) begin
                count_out <= PRESET;
            end else if (enable_in && (step_up || step_dn)) begin
                step_out <= 1'b1;
                dir_out  <= step_up;
                if (step_up) begin
                    count_out    <= count_out + WIDTH'(1);
                    overflow_out <= (count_out == CNT_MAX);
                end else begin
                    count_out     <= count_out - WIDTH'(1);
                    underflow_out <= (count_out == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// ----------------------------------------------------------------------------
// tb_quad_decoder_counter
//   Directed checks of reset/init, stepping, wrap, filtering, errors, preset
//   and asynchronous reset, followed by a randomized walk of encoder states
//   (with short glitches) compared against a position-arithmetic model.
// ----------------------------------------------------------------------------
module tb_quad_decoder_counter;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       preset_in = 1'b0;
    logic       enable_in = 1'b1;
    logic       qa_in = 1'b0;
    logic       qb_in = 1'b0;
    logic       err_clr_in = 1'b0;
    logic [9:0] count_out;
    logic       dir_out;
    logic       step_out;
    logic       overflow_out;
    logic       underflow_out;
    logic       err_out;
    logic       ready_out;

    int n_cmp = 0;
    int n_bad = 0;
    int n_step = 0;
    int n_ovf = 0;
    int n_unf = 0;

    // Position of each {A,B} value along the up sequence 00,10,11,01.
    int gpos [4] = '{0, 3, 1, 2};

    quad_decoder_counter dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .preset_in    (preset_in),
        .enable_in    (enable_in),
        .qa_in        (qa_in),
        .qb_in        (qb_in),
        .err_clr_in   (err_clr_in),
        .count_out    (count_out),
        .dir_out      (dir_out),
        .step_out     (step_out),
        .overflow_out (overflow_out),
        .underflow_out(underflow_out),
        .err_out      (err_out),
        .ready_out    (ready_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (step_out)      n_step++;
        if (overflow_out)  n_ovf++;
        if (underflow_out) n_unf++;
    endtask

    task automatic do_reset(input logic a, input logic b);
        rst_in     = 1'b1;
        qa_in      = a;
        qb_in      = b;
        preset_in  = 1'b0;
        enable_in  = 1'b1;
        err_clr_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int exp_cnt;
        int exp_dir;
        int exp_err;
        int exp_steps;
        int exp_ovf;
        int exp_unf;
        int cur;
        int nxt;
        int d;
        int en;
        int clr;
        int ch;
        int old_cnt;
        logic [1:0] seq [4];

        // ---- Reset release with pins held at 11 ----
        rst_in = 1'b1;
        qa_in  = 1'b1;
        qb_in  = 1'b1;
        tick();
        check("rst_count", count_out, 0);
        check("rst_dir", dir_out, 1);
        check("rst_ready", ready_out, 0);
        tick();
        rst_in = 1'b0;
        n_step = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("init_ready_e%0d", k), ready_out, (k == 5) ? 1 : 0);
        end
        repeat (5) tick();
        check("init_count", count_out, 0);
        check("init_err", err_out, 0);
        check("init_steps", n_step, 0);

        // ---- Four up steps, latency 6 edges each ----
        do_reset(1'b0, 1'b0);
        n_step = 0;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int s = 0; s < 4; s++) begin
            {qa_in, qb_in} = seq[s];
            for (int t = 1; t <= 10; t++) begin
                tick();
                if (t == 5) check($sformatf("up%0d_before", s), count_out, s);
                if (t == 6) begin
                    check($sformatf("up%0d_count", s), count_out, s + 1);
                    check($sformatf("up%0d_step", s), step_out, 1);
                end
            end
        end
        check("up_final_count", count_out, 4);
        check("up_final_dir", dir_out, 1);
        check("up_step_pulses", n_step, 4);

        // ---- Underflow then overflow ----
        do_reset(1'b0, 1'b0);
        n_unf = 0;
        n_ovf = 0;
        {qa_in, qb_in} = 2'b01;
        repeat (6) tick();
        check("unf_count", count_out, 1023);
        check("unf_dir", dir_out, 0);
        check("unf_pulse", underflow_out, 1);
        tick();
        check("unf_pulse_end", underflow_out, 0);
        repeat (3) tick();
        {qa_in, qb_in} = 2'b00;
        repeat (6) tick();
        check("ovf_count", count_out, 0);
        check("ovf_pulse", overflow_out, 1);
        check("ovf_dir", dir_out, 1);
        repeat (4) tick();
        check("wrap_unf_total", n_unf, 1);
        check("wrap_ovf_total", n_ovf, 1);

        // ---- Glitch filtering ----
        n_step = 0;
        qa_in = 1'b1;
        repeat (2) tick();
        qa_in = 1'b0;
        repeat (10) tick();
        check("glitch2_count", count_out, 0);
        check("glitch2_steps", n_step, 0);
        qa_in = 1'b1;
        repeat (10) tick();
        check("glitch3_count", count_out, 1);

        // ---- Illegal transition and error clear ----
        do_reset(1'b0, 1'b0);
        {qa_in, qb_in} = 2'b11;
        repeat (5) tick();
        check("ill_err_e5", err_out, 0);
        tick();
        check("ill_err_e6", err_out, 1);
        check("ill_step", step_out, 0);
        check("ill_count", count_out, 0);
        repeat (4) tick();
        err_clr_in = 1'b1;
        tick();
        err_clr_in = 1'b0;
        check("errclr", err_out, 0);
        {qa_in, qb_in} = 2'b00;
        repeat (5) tick();
        err_clr_in = 1'b1;
        tick();
        err_clr_in = 1'b0;
        check("err_set_wins", err_out, 1);
        check("ill2_count", count_out, 0);

        // ---- Preset coincident with a down step from 0 ----
        do_reset(1'b0, 1'b0);
        {qa_in, qb_in} = 2'b01;
        repeat (5) tick();
        preset_in = 1'b1;
        tick();
        preset_in = 1'b0;
        check("preset_count", count_out, 253);
        check("preset_step", step_out, 0);
        check("preset_dir", dir_out, 1);
        check("preset_unf", underflow_out, 0);
        repeat (4) tick();
        check("preset_hold", count_out, 253);

        // ---- Async reset between edges ----
        {qa_in, qb_in} = 2'b10;
        repeat (10) tick();
        check("pre_rst_err", err_out, 1);
        {qa_in, qb_in} = 2'b00;
        repeat (6) tick();
        check("pre_rst_step", step_out, 1);
        check("pre_rst_count", count_out, 252);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_count", count_out, 0);
        check("arst_step", step_out, 0);
        check("arst_err", err_out, 0);
        check("arst_dir", dir_out, 1);
        check("arst_ready", ready_out, 0);

        // ---- Randomized walk against the position model ----
        do_reset(1'b0, 1'b0);
        exp_cnt = 0; exp_dir = 1; exp_err = 0;
        exp_steps = 0; exp_ovf = 0; exp_unf = 0;
        n_step = 0; n_ovf = 0; n_unf = 0;
        cur = 0;
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                ch = int'($urandom_range(0, 1));
                if (ch == 0) qa_in = ~qa_in; else qb_in = ~qb_in;
                repeat ($urandom_range(1, 2)) tick();
                {qa_in, qb_in} = 2'(cur);
                repeat ($urandom_range(1, 2)) tick();
            end
            nxt = int'($urandom_range(0, 3));
            en  = ($urandom_range(0, 4) != 0) ? 1 : 0;
            clr = ($urandom_range(0, 4) == 0) ? 1 : 0;
            {qa_in, qb_in} = 2'(nxt);
            enable_in  = en[0];
            err_clr_in = clr[0];
            tick();
            err_clr_in = 1'b0;
            repeat (9) tick();

            d = (gpos[nxt] - gpos[cur] + 4) % 4;
            if (clr == 1) exp_err = 0;
            if (d == 2) exp_err = 1;
            if (en == 1 && (d == 1 || d == 3)) begin
                old_cnt = exp_cnt;
                exp_steps++;
                if (d == 1) begin
                    exp_cnt = (exp_cnt + 1) % 1024;
                    exp_dir = 1;
                    if (old_cnt == 1023) exp_ovf++;
                end else begin
                    exp_cnt = (exp_cnt + 1023) % 1024;
                    exp_dir = 0;
                    if (old_cnt == 0) exp_unf++;
                end
            end
            cur = nxt;
            check($sformatf("rnd%0d_count", s), count_out, exp_cnt);
            check($sformatf("rnd%0d_dir", s), dir_out, exp_dir);
            check($sformatf("rnd%0d_err", s), err_out, exp_err);
        end
        check("rnd_steps", n_step, exp_steps);
        check("rnd_ovf", n_ovf, exp_ovf);
        check("rnd_unf", n_unf, exp_unf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
